// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA raster timing generator:
//   - vga_timing_t : one complete set of horizontal/vertical raster timings
//   - VGA_640X480  : 640x480@60 preset (25.175 MHz pixel clock)
//   - VGA_800X600  : 800x600@60 preset (40 MHz pixel clock)
//   - vga_decode_t : per-pixel decode of the raster counters
//   - h_total / v_total / min_cw : helpers for sizing the counters
// ---------------------------------------------------------------------------
package vga_pkg;

  typedef struct packed {
    int h_display;
    int h_front;
    int h_sync;
    int h_back;
    int v_display;
    int v_front;
    int v_sync;
    int v_back;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_display: 640, h_front: 16, h_sync: 96,  h_back: 48,
    v_display: 480, v_front: 10, v_sync: 2,   v_back: 33
  };

  localparam vga_timing_t VGA_800X600 = '{
    h_display: 800, h_front: 40, h_sync: 128, h_back: 88,
    v_display: 600, v_front: 1,  v_sync: 4,   v_back: 23
  };

  // Decode of the current (h,v) position, before the polarity is applied.
  typedef struct packed {
    logic hs_act;
    logic vs_act;
    logic video_on;
    logic line_start;
    logic frame_start;
  } vga_decode_t;

  function automatic int h_total(input vga_timing_t t);
    return t.h_display + t.h_front + t.h_sync + t.h_back;
  endfunction

  function automatic int v_total(input vga_timing_t t);
    return t.v_display + t.v_front + t.v_sync + t.v_back;
  endfunction

  // Smallest counter width whose range 0..2^w-1 covers both totals.
  function automatic int min_cw(input int htot, input int vtot);
    int m;
    int w;
    m = (htot > vtot) ? htot : vtot;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 << i) < m) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/vga_wrap_cnt.sv
// ---------------------------------------------------------------------------
// vga_wrap_cnt
// Modulo-N up counter with enable and synchronous reset.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the count to 0
//   ce   : count enable; the count advances by one per enabled edge
//   cnt  : current count, 0 .. N-1
//   wrap : high while cnt == N-1, i.e. the next enabled edge wraps to 0
// wrap is a plain terminal-count decode, not qualified by ce, so it can be
// ANDed with the enable to cascade a second counter.
// ---------------------------------------------------------------------------
module vga_wrap_cnt #(
  parameter int N = 800,
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (ce) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt  = cnt_reg;
  assign wrap = (cnt_reg == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA/VESA raster timing generator with a pixel clock enable.
//   clk         : system clock
//   rst         : synchronous active-high reset (priority over ce)
//   ce          : pixel enable; one pixel advances per clk edge with ce=1
//   hsync       : horizontal sync, HSYNC_POL level while active
//   vsync       : vertical sync, VSYNC_POL level while active
//   video_on    : high inside the active display area
//   x, y        : position of the current output pixel (blanking included)
//   line_start  : high for the output pixel with x=0
//   frame_start : high for the output pixel with x=0, y=0
//   frame_cnt   : completed-frame count, wraps modulo 2^FW
// All outputs are registered from the decode of the counters as they stand
// before the edge, so they trail the internal (h,v) by one pixel.
// CW must satisfy 2^CW >= max(H_TOTAL, V_TOTAL); vga_pkg::min_cw gives it.
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_DISPLAY = VGA_640X480.h_display,
  parameter int   H_FRONT   = VGA_640X480.h_front,
  parameter int   H_SYNC    = VGA_640X480.h_sync,
  parameter int   H_BACK    = VGA_640X480.h_back,
  parameter int   V_DISPLAY = VGA_640X480.v_display,
  parameter int   V_FRONT   = VGA_640X480.v_front,
  parameter int   V_SYNC    = VGA_640X480.v_sync,
  parameter int   V_BACK    = VGA_640X480.v_back,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   CW        = 10,
  parameter int   FW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Thresholds are held one bit wider than the counters: with a zero back
  // porch the sync end equals the total, which may be exactly 2^CW.
  localparam int CWX = CW + 1;
  localparam logic [CW:0] H_ACT_END = CWX'(H_DISPLAY);
  localparam logic [CW:0] HS_START  = CWX'(H_DISPLAY + H_FRONT);
  localparam logic [CW:0] HS_END    = CWX'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CW:0] V_ACT_END = CWX'(V_DISPLAY);
  localparam logic [CW:0] VS_START  = CWX'(V_DISPLAY + V_FRONT);
  localparam logic [CW:0] VS_END    = CWX'(V_DISPLAY + V_FRONT + V_SYNC);

  // -------------------------------------------------------------------------
  // Raster counters: v steps only on the edge where h wraps.
  // -------------------------------------------------------------------------
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          v_ce;

  assign v_ce = ce & h_wrap;

  vga_wrap_cnt #(
    .N (H_TOTAL),
    .W (CW)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .cnt  (h_cnt),
    .wrap (h_wrap)
  );

  vga_wrap_cnt #(
    .N (V_TOTAL),
    .W (CW)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .ce   (v_ce),
    .cnt  (v_cnt),
    .wrap (v_wrap)
  );

  // -------------------------------------------------------------------------
  // Decode of the current counter position.
  // -------------------------------------------------------------------------
  logic [CW:0] h_ext;
  logic [CW:0] v_ext;
  vga_decode_t dec;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  always_comb begin
    dec             = '0;
    dec.hs_act      = (h_ext >= HS_START) && (h_ext < HS_END);
    dec.vs_act      = (v_ext >= VS_START) && (v_ext < VS_END);
    dec.video_on    = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    dec.line_start  = (h_cnt == '0);
    dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  // -------------------------------------------------------------------------
  // Output registers. They load only on enabled edges, so with ce low every
  // output (including a strobe) simply holds its last value.
  // -------------------------------------------------------------------------
  logic          hsync_reg;
  logic          vsync_reg;
  logic          video_on_reg;
  logic [CW-1:0] x_reg;
  logic [CW-1:0] y_reg;
  logic          line_start_reg;
  logic          frame_start_reg;
  logic [FW-1:0] frame_cnt_reg;
  // Set by the first frame_start after reset: that first frame is the one
  // just beginning, not a completed one, so it must not be counted.
  logic          started_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      video_on_reg    <= 1'b0;
      x_reg           <= '0;
      y_reg           <= '0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
      started_reg     <= 1'b0;
    end else if (ce) begin
      hsync_reg       <= dec.hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_reg       <= dec.vs_act ? VSYNC_POL : ~VSYNC_POL;
      video_on_reg    <= dec.video_on;
      x_reg           <= h_cnt;
      y_reg           <= v_cnt;
      line_start_reg  <= dec.line_start;
      frame_start_reg <= dec.frame_start;
      if (dec.frame_start) begin
        started_reg <= 1'b1;
        if (started_reg) begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign x           = x_reg;
  assign y           = y_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

  // v_wrap is only needed by a cascaded third counter; nothing here uses it.
  logic unused_ok;
  assign unused_ok = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Four instances share one clock, each with its own rst/ce:
//   u_def : default 640x480 timing (first pixel, hsync, line period, reset)
//   u_vt  : narrow 12-pixel lines with the default 525-line vertical timing
//           (vsync window, frame period, frame_cnt, mid-frame reset)
//   u_sml : H 4/1/1/1, V 3/1/1/1, active-high syncs (vector table,
//           exhaustive two-frame decode, half-rate ce)
//   u_fw2 : same small raster, active-low syncs, FW=2 (frame_cnt wrap)
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- u_def ----------------
  logic       rst_d, ce_d, hs_d, vs_d, von_d, ls_d, fs_d;
  logic [9:0] x_d, y_d;
  logic [15:0] fc_d;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_d), .ce(ce_d), .hsync(hs_d), .vsync(vs_d),
    .video_on(von_d), .x(x_d), .y(y_d), .line_start(ls_d),
    .frame_start(fs_d), .frame_cnt(fc_d)
  );

  // ---------------- u_vt ----------------
  logic       rst_v, ce_v, hs_v, vs_v, von_v, ls_v, fs_v;
  logic [9:0] x_v, y_v;
  logic [15:0] fc_v;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)
  ) u_vt (
    .clk(clk), .rst(rst_v), .ce(ce_v), .hsync(hs_v), .vsync(vs_v),
    .video_on(von_v), .x(x_v), .y(y_v), .line_start(ls_v),
    .frame_start(fs_v), .frame_cnt(fc_v)
  );

  // ---------------- u_sml ----------------
  logic       rst_s, ce_s, hs_s, vs_s, von_s, ls_s, fs_s;
  logic [2:0] x_s, y_s;
  logic [15:0] fc_s;

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(3), .FW(16)
  ) u_sml (
    .clk(clk), .rst(rst_s), .ce(ce_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(von_s), .x(x_s), .y(y_s), .line_start(ls_s),
    .frame_start(fs_s), .frame_cnt(fc_s)
  );

  // ---------------- u_fw2 ----------------
  logic       rst_f, ce_f, hs_f, vs_f, von_f, ls_f, fs_f;
  logic [2:0] x_f, y_f;
  logic [1:0] fc_f;

  vga_timing_gen #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CW(3), .FW(2)
  ) u_fw2 (
    .clk(clk), .rst(rst_f), .ce(ce_f), .hsync(hs_f), .vsync(vs_f),
    .video_on(von_f), .x(x_f), .y(y_f), .line_start(ls_f),
    .frame_start(fs_f), .frame_cnt(fc_f)
  );

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Small-raster pixel n after reset (7x6, hsync at h=5, vsync at v=4,
  // active 4x3), packed as {hs,vs,von,x,y,ls,fs,fc}, syncs active-high.
  function automatic logic [26:0] exp_sml(input int n);
    int h;
    int v;
    logic [2:0] hx;
    logic [2:0] vy;
    logic [15:0] f;
    h  = n % 7;
    v  = (n / 7) % 6;
    hx = 3'(h);
    vy = 3'(v);
    f  = 16'(n / 42);
    return {h == 5, v == 4, (h < 4) && (v < 3), hx, vy, h == 0,
            (n % 42) == 0, f};
  endfunction

  function automatic logic [26:0] sv(input logic hs, input logic vs,
                                     input logic von, input logic [2:0] xx,
                                     input logic [2:0] yy, input logic ls,
                                     input logic fs);
    return {hs, vs, von, xx, yy, ls, fs, 16'd0};
  endfunction

  typedef struct {
    logic        rst;
    logic        ce;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[15];

  // Bench bookkeeping
  int   xy_err, hs_cnt, hs_first, hs_last, ls_second, vs_low_d;
  logic von639, von640;
  int   vs_low, vs_first, vs_last, vt_trans, vt_bad, fs_n;
  int   fs_idx[4];
  int   fs_fc[4];
  logic vs_prev;
  int   m, pix, hr_n;
  int   hr_k[2];
  logic [26:0] e;

  initial begin
    rst_d = 1'b1; ce_d = 1'b0;
    rst_v = 1'b1; ce_v = 1'b0;
    rst_s = 1'b1; ce_s = 1'b0;
    rst_f = 1'b1; ce_f = 1'b0;
    @(negedge clk);

    // ---------------- package helpers ----------------
    check("min_cw_640x480",
          64'(min_cw(h_total(VGA_640X480), v_total(VGA_640X480))), 64'd10);
    check("min_cw_800x600",
          64'(min_cw(h_total(VGA_800X600), v_total(VGA_800X600))), 64'd11);

    // ---------------- u_def: first pixel, hsync, line period ----------------
    rst_d = 1'b1; ce_d = 1'b1;
    tick();
    check("def_reset", 64'({hs_d, vs_d, von_d, x_d, y_d, ls_d, fs_d, fc_d}),
          64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0}));
    rst_d = 1'b0;
    tick();
    check("def_first", 64'({hs_d, vs_d, von_d, x_d, y_d, ls_d, fs_d, fc_d}),
          64'({1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'd0}));
    xy_err = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_second = -1;
    vs_low_d = 0; von639 = 1'b0; von640 = 1'b1;
    for (int n = 1; n <= 1600; n++) begin
      tick();
      if (int'(x_d) != n % 800 || int'(y_d) != n / 800) xy_err++;
      if (!vs_d) vs_low_d++;
      if (n < 800 && !hs_d) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(x_d);
        hs_last = int'(x_d);
      end
      if (n == 639) von639 = von_d;
      if (n == 640) von640 = von_d;
      if (ls_d && ls_second < 0) ls_second = n;
    end
    check("def_xy_track", 64'(xy_err), 64'd0);
    check("def_hsync_width", 64'(hs_cnt), 64'd96);
    check("def_hsync_first_x", 64'(hs_first), 64'd656);
    check("def_hsync_last_x", 64'(hs_last), 64'd751);
    check("def_line_period", 64'(ls_second), 64'd800);
    check("def_von_x639", 64'(von639), 64'd1);
    check("def_von_x640", 64'(von640), 64'd0);
    check("def_vsync_idle", 64'(vs_low_d), 64'd0);
    // Output pixel 1600 is (0,2); 299 more edges leave internal h=300.
    for (int n = 0; n < 299; n++) tick();
    check("def_pre_rst_xy", 64'({x_d, y_d}), 64'({10'd299, 10'd2}));
    rst_d = 1'b1;
    tick();
    check("def_rst_h300", 64'({hs_d, vs_d, von_d, x_d, y_d, ls_d, fs_d, fc_d}),
          64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0}));
    rst_d = 1'b0;
    tick();
    check("def_restart", 64'({hs_d, vs_d, von_d, x_d, y_d, ls_d, fs_d, fc_d}),
          64'({1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'd0}));
    ce_d = 1'b0;

    // ---------------- u_vt: mid-frame reset, vsync, frame counter ----------------
    rst_v = 1'b1; ce_v = 1'b1;
    tick();
    rst_v = 1'b0;
    for (int n = 0; n <= 200 * 12 + 4; n++) tick();
    check("vt_pre_rst_xy", 64'({x_v, y_v}), 64'({10'd4, 10'd200}));
    rst_v = 1'b1;
    tick();
    check("vt_rst_v200", 64'({hs_v, vs_v, von_v, x_v, y_v, ls_v, fs_v, fc_v}),
          64'({1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 16'd0}));
    rst_v = 1'b0;
    tick();
    check("vt_restart", 64'({hs_v, vs_v, von_v, x_v, y_v, ls_v, fs_v, fc_v}),
          64'({1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 16'd0}));
    vs_low = 0; vs_first = -1; vs_last = -1; vt_trans = 0; vt_bad = 0;
    fs_n = 0; vs_prev = vs_v;
    for (int i = 0; i < 4; i++) begin
      fs_idx[i] = -1;
      fs_fc[i]  = -1;
    end
    for (int n = 1; n <= 3 * 6300; n++) begin
      tick();
      if (vs_v != vs_prev) begin
        vt_trans++;
        if (x_v != 10'd0) vt_bad++;
      end
      vs_prev = vs_v;
      if (n < 6300 && !vs_v) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(y_v);
        vs_last = int'(y_v);
      end
      if (fs_v) begin
        if (fs_n < 4) begin
          fs_idx[fs_n] = n;
          fs_fc[fs_n]  = int'(fc_v);
        end
        fs_n++;
      end
    end
    check("vt_vsync_cycles", 64'(vs_low), 64'd24);
    check("vt_vsync_first_y", 64'(vs_first), 64'd490);
    check("vt_vsync_last_y", 64'(vs_last), 64'd491);
    check("vt_vsync_edges", 64'(vt_trans), 64'd6);
    check("vt_vsync_edge_x0", 64'(vt_bad), 64'd0);
    check("vt_frame_starts", 64'(fs_n), 64'd3);
    check("vt_frame1_at", 64'(fs_idx[0]), 64'd6300);
    check("vt_frame2_at", 64'(fs_idx[1]), 64'd12600);
    check("vt_frame3_at", 64'(fs_idx[2]), 64'd18900);
    check("vt_fcnt_1", 64'(fs_fc[0]), 64'd1);
    check("vt_fcnt_2", 64'(fs_fc[1]), 64'd2);
    check("vt_fcnt_3", 64'(fs_fc[2]), 64'd3);
    ce_v = 1'b0;

    // ---------------- u_sml: vector table ----------------
    //                  rst   ce    hs    vs    von   x     y     ls    fs
    vecs[0]  = '{1'b1, 1'b1, sv(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0)};
    vecs[1]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1)};
    vecs[2]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0)};
    vecs[3]  = '{1'b0, 1'b0, sv(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0)};
    vecs[4]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0)};
    vecs[5]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b0)};
    vecs[6]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b0)};
    vecs[7]  = '{1'b0, 1'b1, sv(1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0)};
    vecs[8]  = '{1'b0, 1'b0, sv(1'b1, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b0)};
    vecs[9]  = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0)};
    vecs[10] = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd0, 3'd1, 1'b1, 1'b0)};
    vecs[11] = '{1'b1, 1'b1, sv(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0)};
    vecs[12] = '{1'b0, 1'b0, sv(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0)};
    vecs[13] = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, 1'b1)};
    vecs[14] = '{1'b0, 1'b1, sv(1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0)};
    for (int i = 0; i < 15; i++) begin
      rst_s = vecs[i].rst;
      ce_s  = vecs[i].ce;
      tick();
      check($sformatf("sml_vec%0d", i),
            64'({hs_s, vs_s, von_s, x_s, y_s, ls_s, fs_s, fc_s}),
            64'(vecs[i].exp));
    end

    // ---------------- u_sml: exhaustive two frames ----------------
    rst_s = 1'b1; ce_s = 1'b1;
    tick();
    rst_s = 1'b0;
    for (int n = 0; n <= 84; n++) begin
      tick();
      check($sformatf("sml_pix%0d", n),
            64'({hs_s, vs_s, von_s, x_s, y_s, ls_s, fs_s, fc_s}),
            64'(exp_sml(n)));
    end

    // ---------------- u_sml: ce at half rate ----------------
    rst_s = 1'b1; ce_s = 1'b1;
    tick();
    rst_s = 1'b0;
    m = 0; hr_n = 0; hr_k[0] = -1; hr_k[1] = -1;
    for (int k = 0; k < 169; k++) begin
      ce_s = (k % 2 == 0);
      tick();
      if (ce_s) begin
        pix = m;
        m++;
        if (fs_s) begin
          if (hr_n < 2) hr_k[hr_n] = k;
          hr_n++;
        end
      end else begin
        pix = m - 1;
      end
      check($sformatf("half_clk%0d", k),
            64'({hs_s, vs_s, von_s, x_s, y_s, ls_s, fs_s, fc_s}),
            64'(exp_sml(pix)));
    end
    check("half_frame_period", 64'(hr_k[1] - hr_k[0]), 64'd84);
    ce_s = 1'b0;

    // ---------------- u_fw2: frame counter wrap ----------------
    rst_f = 1'b1; ce_f = 1'b1;
    tick();
    rst_f = 1'b0;
    for (int n = 0; n <= 4 * 42; n++) begin
      tick();
      e = exp_sml(n);
      e[15:0] = 16'((n / 42) % 4);
      check($sformatf("fw2_pix%0d", n),
            64'({~hs_f, ~vs_f, von_f, x_f, y_f, ls_f, fs_f, 14'd0, fc_f}),
            64'(e));
    end
    ce_f = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
